pl_fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory address, selects the next PC, and registers the fetched word into IF/ID.

---
 rtl/pl_mips_pkg.sv | 26 ++
 rtl/pl_fetch_stage_if_id_reg.sv | 37 +++
 rtl/pl_fetch_stage.sv | 106 ++++++++++
 tb/tb_pl_fetch_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pl_mips_pkg.sv
// Shared MIPS pipeline types and constants: fetch redirect select,
// exception cause encoding, exception vectors and the pipeline NOP word.
package pl_mips_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_JUMP   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_EXC    = 2'd3
  } fetch_sel_e;

  typedef enum logic [1:0] {
    EXC_NONE  = 2'b00,
    EXC_UNDEF = 2'b01,
    EXC_OVF   = 2'b10
  } exc_cause_e;

  localparam logic [31:0] OVERFLOW_HANDLER_ADDR  = 32'h8000_0180;
  localparam logic [31:0] UNDEFINED_HANDLER_ADDR = 32'h8000_0100;
  localparam logic [31:0] NOP_WORD               = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pl_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: sync reset, flush to a bubble, stall hold, else load.
module pl_if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc4_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc4_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // Flush has priority over stall so a redirect always kills the held word.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc4_q   <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc4_q   <= pc4_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pl_fetch_stage.sv
// MIPS IF stage: PC register, next-PC arbitration, exception-entry FSM
// and the IF/ID pipeline register.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_RUN     | normal fetch; an exception vectors and latches its cause
//  ST_HANDLER | in exception handler; new exceptions ignored until reset
module pl_fetch_stage
  import pl_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_undef,
  input  logic        exc_ovf,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        in_handler,
  output logic [1:0]  exc_cause
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  logic [0:0]  state_q, state_d;
  exc_cause_e  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        ovf_act, undef_act;
  logic        redirect;
  fetch_sel_e  sel;

  assign pc_plus4  = pc_q + 32'd4;
  assign ovf_act   = (state_q == ST_RUN) && exc_ovf;
  assign undef_act = (state_q == ST_RUN) && exc_undef;

  always_comb begin
    sel = SEL_SEQ;
    if (ovf_act || undef_act) sel = SEL_EXC;
    else if (branch_taken)    sel = SEL_BRANCH;
    else if (jump)            sel = SEL_JUMP;
  end

  assign redirect = (sel != SEL_SEQ);

  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_EXC:    pc_d = ovf_act ? OVERFLOW_HANDLER_ADDR : UNDEFINED_HANDLER_ADDR;
      SEL_BRANCH: pc_d = word_align(branch_target);
      SEL_JUMP:   pc_d = word_align(jump_target);
      SEL_SEQ:    pc_d = stall_if ? pc_q : pc_plus4;
      default:    pc_d = pc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (ovf_act || undef_act) begin
      state_d = ST_HANDLER;
      cause_d = ovf_act ? EXC_OVF : EXC_UNDEF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      cause_q <= EXC_NONE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  pl_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall_if),
    .flush   (redirect),
    .pc4_i   (pc_plus4),
    .instr_i (imem_instr),
    .pc4_o   (if_id_pc4),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

  assign imem_addr  = pc_q;
  assign in_handler = (state_q == ST_HANDLER);
  assign exc_cause  = cause_q;

endmodule

// File: tb/tb_pl_fetch_stage.sv
// Directed bench for pl_fetch_stage: a reference model pushes expected
// state per cycle into a scoreboard that is popped after each clock edge.
module tb_pl_fetch_stage;
  import pl_mips_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_if = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        exc_undef = 1'b0;
  logic        exc_ovf = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        in_handler;
  logic [1:0]  exc_cause;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        hnd;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb imem_instr = mem_f(imem_addr);

  pl_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_if      (stall_if),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exc_undef     (exc_undef),
    .exc_ovf       (exc_ovf),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .in_handler    (in_handler),
    .exc_cause     (exc_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance the model, drive the inputs, clock once and compare the popped entry.
  task automatic step(input logic rst, input logic stl, input logic br,
                      input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                      input logic ov, input logic ud);
    exp_t e;
    reset = rst; stall_if = stl; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; exc_ovf = ov; exc_undef = ud;
    if (rst) begin
      m = '{pc: TB_RESET_PC, instr: TB_NOP, pc4: 32'h0, valid: 1'b0, hnd: 1'b0, cause: 2'b00};
    end else if (!m.hnd && (ov || ud)) begin
      m.cause = ov ? 2'b10 : 2'b01;
      m.hnd   = 1'b1;
      m.pc    = ov ? OVERFLOW_HANDLER_ADDR : UNDEFINED_HANDLER_ADDR;
      m.instr = TB_NOP; m.pc4 = 32'h0; m.valid = 1'b0;
    end else if (br || jp) begin
      m.pc    = (br ? bt : jt) & 32'hFFFF_FFFC;
      m.instr = TB_NOP; m.pc4 = 32'h0; m.valid = 1'b0;
    end else if (!stl) begin
      m.instr = mem_f(m.pc);
      m.pc4   = m.pc + 32'd4;
      m.valid = 1'b1;
      m.pc    = m.pc + 32'd4;
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("imem_addr", imem_addr, e.pc);
      chk("if_id_instr", if_id_instr, e.instr);
      chk("if_id_pc4", if_id_pc4, e.pc4);
      chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
      chk("in_handler", {31'h0, in_handler}, {31'h0, e.hnd});
      chk("exc_cause", {30'h0, exc_cause}, {30'h0, e.cause});
    end
    reset = 1'b0; stall_if = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    exc_ovf = 1'b0; exc_undef = 1'b0;
  endtask

  initial begin
    m = '0;
    #2;
    // Reset and first sequential fetch
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", imem_addr, TB_RESET_PC);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_addr", imem_addr, 32'h4);
    chk("t1_instr", if_id_instr, 32'h2008_0005);
    chk("t1_pc4", if_id_pc4, 32'h4);
    // Advance to 0x10, then stall two cycles
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_pre_addr", imem_addr, 32'h10);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_stall_addr", imem_addr, 32'h10);
    chk("t2_stall_pc4", if_id_pc4, 32'h10);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_resume", imem_addr, 32'h14);
    // Branch + jump + stall together: branch wins and flushes
    step(0, 1, 1, 32'h40, 1, 32'h80, 0, 0);
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_valid", {31'h0, if_id_valid}, 32'h0);
    chk("t3_instr", if_id_instr, TB_NOP);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h103, 0, 0);
    chk("jump_align", imem_addr, 32'h100);
    // Both exceptions at PC 0x20: overflow wins
    step(0, 0, 0, 0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("t4_addr", imem_addr, OVERFLOW_HANDLER_ADDR);
    chk("t4_hnd", {31'h0, in_handler}, 32'h1);
    chk("t4_cause", {30'h0, exc_cause}, 32'h2);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_cause_frozen", {30'h0, exc_cause}, 32'h2);
    step(0, 0, 1, 32'h200, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // PC wrap from the top of the address space
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_addr", imem_addr, 32'h0);
    chk("t5_pc4", if_id_pc4, 32'h0);
    // Reset in handler with stall asserted
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("t6_addr", imem_addr, TB_RESET_PC);
    chk("t6_hnd", {31'h0, in_handler}, 32'h0);
    chk("t6_cause", {30'h0, exc_cause}, 32'h0);
    chk("t6_valid", {31'h0, if_id_valid}, 32'h0);
    // Undefined-instruction exception alone, then overflow ignored
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    chk("undef_addr", imem_addr, UNDEFINED_HANDLER_ADDR);
    chk("undef_cause", {30'h0, exc_cause}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("undef_frozen", {30'h0, exc_cause}, 32'h1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
